// File: rtl/adc_scan_uart_tx.sv
// Channel scanner driving an external mux/ADC plus async serial sender.
// Conversion of the next sample overlaps transmission of the current one.
module adc_scan_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 8,
  parameter int CH_W       = 4,
  parameter int BAUD_DIV   = 104,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              eoc,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dsr,
  output logic              mux_en,
  output logic [CH_W-1:0]   canale,
  output logic              soc,
  output logic              load_dato,
  output logic              data_out,
  output logic              tx_busy,
  output logic              error
);

  localparam int BW   = $clog2(BAUD_DIV);
  localparam int BITW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_MUX    = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_SOC    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;

  localparam logic [2:0] T_IDLE  = 3'd0;
  localparam logic [2:0] T_START = 3'd1;
  localparam logic [2:0] T_DATA  = 3'd2;
  localparam logic [2:0] T_PAR   = 3'd3;
  localparam logic [2:0] T_STOP  = 3'd4;

  logic [2:0]        s_state;
  logic [2:0]        t_state;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic [BW-1:0]     baud_q;
  logic [BITW-1:0]   bit_q;

  logic bit_end;
  logic stop_end;
  logic tx_free;
  logic tx_load;
  logic capture;

  // Handshake decode shared by scanner, buffer and sender
  always_comb begin
    bit_end  = (baud_q == BW'(BAUD_DIV - 1));
    stop_end = (t_state == T_STOP) && bit_end;
    tx_free  = (t_state == T_IDLE) || stop_end;
    tx_load  = tx_free && buf_full && dsr;
    capture  = (s_state == S_WAIT) && !eoc && !buf_full;
  end

  // Scanner: select channel, start conversion, capture when buffer free
  always_ff @(posedge clock) begin
    if (reset) begin
      s_state   <= S_MUX;
      mux_en    <= 1'b0;
      soc       <= 1'b0;
      load_dato <= 1'b0;
      canale    <= '0;
    end else begin
      load_dato <= 1'b0;
      unique case (s_state)
        S_MUX: begin
          mux_en  <= 1'b1;
          s_state <= S_SETTLE;
        end
        S_SETTLE: s_state <= S_SOC;
        S_SOC: begin
          soc     <= 1'b1;
          s_state <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            load_dato <= 1'b1;
            mux_en    <= 1'b0;
            s_state   <= S_NEXT;
          end
        end
        S_NEXT: begin
          soc     <= 1'b0;
          s_state <= S_MUX;
          if (canale == CH_W'(NUM_CH - 1))
            canale <= '0;
          else
            canale <= canale + 1'b1;
        end
        default: s_state <= S_MUX;
      endcase
    end
  end

  // One-entry holding buffer between scanner and sender
  always_ff @(posedge clock) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_q    <= '0;
    end else if (capture) begin
      buf_full <= 1'b1;
      buf_q    <= data_in;
    end else if (tx_load) begin
      buf_full <= 1'b0;
    end
  end

  // Sender: start, data MSB first, optional parity, stop; chains frames
  always_ff @(posedge clock) begin
    if (reset) begin
      t_state  <= T_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      data_out <= 1'b1;
      tx_busy  <= 1'b0;
      error    <= 1'b0;
    end else if (tx_load) begin
      t_state  <= T_START;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= buf_q;
      par_q    <= (^buf_q) ^ 1'(PARITY_ODD);
      data_out <= 1'b0;
      tx_busy  <= 1'b1;
      error    <= 1'b0;
    end else if (tx_free) begin
      t_state  <= T_IDLE;
      baud_q   <= '0;
      data_out <= 1'b1;
      tx_busy  <= 1'b0;
      if (buf_full)
        error <= 1'b1;
    end else if (bit_end) begin
      baud_q <= '0;
      unique case (t_state)
        T_START: begin
          t_state  <= T_DATA;
          data_out <= shift_q[DATA_W-1];
          shift_q  <= shift_q << 1;
          bit_q    <= '0;
        end
        T_DATA: begin
          if (bit_q == BITW'(DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              t_state  <= T_PAR;
              data_out <= par_q;
            end else begin
              t_state  <= T_STOP;
              data_out <= 1'b1;
            end
          end else begin
            data_out <= shift_q[DATA_W-1];
            shift_q  <= shift_q << 1;
            bit_q    <= bit_q + 1'b1;
          end
        end
        T_PAR: begin
          t_state  <= T_STOP;
          data_out <= 1'b1;
        end
        default: t_state <= T_IDLE;
      endcase
    end else begin
      baud_q <= baud_q + BW'(1);
    end
  end

endmodule

// File: tb/tb_adc_scan_uart_tx.sv
// Bench for adc_scan_uart_tx: three parameter sets, frame-level model,
// directed literal checks and a long randomized run.
module tb_adc_scan_uart_tx;

  localparam int B = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       eoc   = 1'b0;
  logic       dsr   = 1'b1;
  logic [7:0] data_in = 8'h00;

  logic       mux_en    [3];
  logic [3:0] canale    [3];
  logic       soc       [3];
  logic       load_dato [3];
  logic       data_out  [3];
  logic       tx_busy   [3];
  logic       error     [3];

  int errs   = 0;
  int checks = 0;

  always #5 clock = ~clock;

  adc_scan_uart_tx #(.DATA_W(8), .NUM_CH(3), .CH_W(4), .BAUD_DIV(B),
    .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clock(clock), .reset(reset), .eoc(eoc), .data_in(data_in), .dsr(dsr),
    .mux_en(mux_en[0]), .canale(canale[0]), .soc(soc[0]),
    .load_dato(load_dato[0]), .data_out(data_out[0]),
    .tx_busy(tx_busy[0]), .error(error[0]));

  adc_scan_uart_tx #(.DATA_W(8), .NUM_CH(8), .CH_W(4), .BAUD_DIV(B),
    .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clock(clock), .reset(reset), .eoc(eoc), .data_in(data_in), .dsr(dsr),
    .mux_en(mux_en[1]), .canale(canale[1]), .soc(soc[1]),
    .load_dato(load_dato[1]), .data_out(data_out[1]),
    .tx_busy(tx_busy[1]), .error(error[1]));

  adc_scan_uart_tx #(.DATA_W(8), .NUM_CH(8), .CH_W(4), .BAUD_DIV(B),
    .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clock(clock), .reset(reset), .eoc(eoc), .data_in(data_in), .dsr(dsr),
    .mux_en(mux_en[2]), .canale(canale[2]), .soc(soc[2]),
    .load_dato(load_dato[2]), .data_out(data_out[2]),
    .tx_busy(tx_busy[2]), .error(error[2]));

  function automatic int nc(int i);
    return (i == 0) ? 3 : 8;
  endfunction
  function automatic bit pe(int i);
    return i != 0;
  endfunction
  function automatic bit po(int i);
    return i == 2;
  endfunction

  // Model: age within a channel step, pending-advance flag, buffer,
  // and the whole frame as a time-ordered bit vector with a position.
  typedef struct {
    int         age;
    bit         nxt;
    int         ch;
    bit         full;
    logic [7:0] smp;
    bit         act;
    int         pos;
    bit         err;
    logic [10:0] frm;
  } mst_t;

  mst_t st [3];
  bit   mdl_on = 1'b0;

  function automatic mst_t step(mst_t s, int i, logic rs, logic e,
                                logic d, logic [7:0] din);
    mst_t n;
    bit cap, free, ld;
    int len;
    n = s;
    if (rs) begin
      n.age = 0; n.nxt = 0; n.ch = 0; n.full = 0;
      n.act = 0; n.pos = 0; n.err = 0;
      return n;
    end
    len  = 10 + int'(pe(i));
    cap  = !s.nxt && s.age == 3 && !e && !s.full;
    free = !s.act || s.pos == len * B - 1;
    ld   = free && s.full && d;
    if (ld) begin
      n.frm = '1;
      n.frm[0] = 1'b0;
      for (int j = 0; j < 8; j++) n.frm[1+j] = s.smp[7-j];
      if (pe(i)) n.frm[9] = (^s.smp) ^ po(i);
      n.act = 1; n.pos = 0; n.err = 0;
    end else if (free) begin
      n.act = 0;
      if (s.full) n.err = 1;
    end else begin
      n.pos = s.pos + 1;
    end
    if (cap) begin
      n.full = 1; n.smp = din;
    end else if (ld) begin
      n.full = 0;
    end
    if (s.nxt) begin
      n.nxt = 0; n.age = 0; n.ch = (s.ch + 1) % nc(i);
    end else if (cap) begin
      n.nxt = 1;
    end else if (s.age < 3) begin
      n.age = s.age + 1;
    end
    return n;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++)
      st[i] <= step(st[i], i, reset, eoc, dsr, data_in);
    if (reset) mdl_on <= 1'b1;
  end

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s u%0d got=%0h want=%0h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model plus invariants
  always @(posedge clock) begin
    logic [9:0] a, e;
    logic dv;
    #1;
    if (mdl_on) begin
      for (int i = 0; i < 3; i++) begin
        dv = st[i].act ? st[i].frm[st[i].pos / B] : 1'b1;
        a = {mux_en[i], canale[i], soc[i], load_dato[i],
             data_out[i], tx_busy[i], error[i]};
        e = {st[i].age >= 1 && !st[i].nxt, 4'(st[i].ch), st[i].age == 3,
             st[i].nxt, dv, st[i].act, st[i].err};
        chk("model", i, 32'(a), 32'(e));
        chk("invariant", i,
            32'((load_dato[i] && !soc[i]) || int'(canale[i]) >= nc(i)), 0);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  logic [9:0] fa;
  int seq, frames;
  logic prev_busy;

  initial begin
    // Frame for A5 after reset, BAUD_DIV=4
    fa = 10'b1101001010;
    reset = 1'b1; eoc = 1'b0; dsr = 1'b1; data_in = 8'hA5;
    tick(); tick();
    reset = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      tick();
      if (k <= 5) chk("t1_load", 0, 32'(load_dato[0]), 32'(k == 4));
      if (k >= 5) chk("t1_line", 0, 32'(data_out[0]), 32'(fa[(k-5)/B]));
      else        chk("t1_idle", 0, 32'(data_out[0]), 1);
      if (k == 5) chk("t1_canale", 0, 32'(canale[0]), 1);
    end

    // Parity, frame length, dsr error and recovery
    reset = 1'b1; data_in = 8'h07;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k >= 41 && k <= 44) begin
        chk("t4_par_even", 1, 32'(data_out[1]), 1);
        chk("t4_par_odd", 2, 32'(data_out[2]), 0);
      end
      if (k >= 45 && k <= 48) chk("t4_stop_busy", 1, 32'(tx_busy[1]), 1);
      if (k == 45) chk("t4_len8", 0, 32'(tx_busy[0]), 0);
      if (k == 49) begin
        chk("t4_len11", 1, 32'(tx_busy[1]), 0);
        chk("t3_err", 1, 32'(error[1]), 1);
        chk("t3_line", 1, 32'(data_out[1]), 1);
        chk("t3_err", 0, 32'(error[0]), 1);
      end
      if (k == 50)
        for (int i = 0; i < 3; i++) begin
          chk("t3_start", i, 32'(data_out[i]), 0);
          chk("t3_clr", i, 32'(error[i]), 0);
          chk("t3_busy", i, 32'(tx_busy[i]), 1);
        end
      if (k == 5) dsr = 1'b0;
      if (k == 49) dsr = 1'b1;
    end

    // Reset in the middle of a data bit
    reset = 1'b1; data_in = 8'($urandom);
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 18; k++) tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t6_line", i, 32'(data_out[i]), 1);
      chk("t6_busy", i, 32'(tx_busy[i]), 0);
      chk("t6_canale", i, 32'(canale[i]), 0);
      chk("t6_err", i, 32'(error[i]), 0);
      chk("t6_ctl", i, 32'({mux_en[i], soc[i], load_dato[i]}), 0);
    end
    reset = 1'b0;

    // Randomized run with stalls, dsr drops and rare resets
    seq = 0; frames = 0; prev_busy = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (reset) seq = 0;
      else if (load_dato[0]) begin
        chk("t2_canale", 0, 32'(canale[0]), 32'(seq % 3));
        seq++;
      end
      if (tx_busy[0] && !prev_busy) frames++;
      prev_busy = tx_busy[0];
      reset   = ($urandom_range(0, 1499) == 0);
      eoc     = ($urandom_range(0, 3) != 0);
      dsr     = ($urandom_range(0, 9) != 0);
      data_in = 8'($urandom);
    end
    chk("t5_frames", 0, 32'(frames >= 10), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
